// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, operation classes and the decoded record.
package decode_pkg;

  // Storage width for pc/imm; narrower datapaths use the low XLEN bits.
  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OP_LUI         = 7'b0110111;
  localparam logic [6:0] OP_AUIPC       = 7'b0010111;
  localparam logic [6:0] OP_JAL         = 7'b1101111;
  localparam logic [6:0] OP_JALR        = 7'b1100111;
  localparam logic [6:0] OP_BRANCH      = 7'b1100011;
  localparam logic [6:0] OP_LOAD        = 7'b0000011;
  localparam logic [6:0] OP_STORE       = 7'b0100011;
  localparam logic [6:0] OP_IMM_REG_ALU = 7'b0010011;
  localparam logic [6:0] OP_REG_REG_ALU = 7'b0110011;
  localparam logic [6:0] OP_FENCE       = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM      = 7'b1110011;

  typedef enum logic [3:0] {
    OPC_NOP     = 4'd0,
    OPC_LUI     = 4'd1,
    OPC_AUIPC   = 4'd2,
    OPC_JAL     = 4'd3,
    OPC_JALR    = 4'd4,
    OPC_BRANCH  = 4'd5,
    OPC_LOAD    = 4'd6,
    OPC_STORE   = 4'd7,
    OPC_ALU_IMM = 4'd8,
    OPC_ALU_REG = 4'd9,
    OPC_FENCE   = 4'd10,
    OPC_SYSTEM  = 4'd11,
    OPC_ILLEGAL = 4'd12
  } op_class_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [XLEN_MAX-1:0] imm;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    op_class_e           op_class;
    logic                rs1_used;
    logic                rs2_used;
    logic                rd_we;
    logic                invalid;
  } decoded_t;

endpackage

// File: rtl/decode_fields.sv
// Combinational RV32I field decoder: instruction word to decoded_t record.
module decode_fields
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output decoded_t        dec
);

  logic [6:0]          opcode;
  logic [4:0]          rd_f;
  logic [4:0]          rs1_f;
  logic [4:0]          rs2_f;
  logic [XLEN_MAX-1:0] imm_i;
  logic [XLEN_MAX-1:0] imm_s;
  logic [XLEN_MAX-1:0] imm_b;
  logic [XLEN_MAX-1:0] imm_u;
  logic [XLEN_MAX-1:0] imm_j;
  logic                rd_class;

  assign opcode = instr[6:0];
  assign rd_f   = instr[11:7];
  assign rs1_f  = instr[19:15];
  assign rs2_f  = instr[24:20];

  // Immediates are sign-extended to the full storage width; truncation to XLEN keeps the sign.
  assign imm_i = {{52{instr[31]}}, instr[31:20]};
  assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
  assign imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    dec               = '0;
    dec.pc[XLEN-1:0]  = pc;
    dec.funct3        = instr[14:12];
    dec.funct7        = instr[31:25];
    dec.op_class      = OPC_NOP;
    rd_class          = 1'b0;
    if (instr[1:0] != 2'b11) begin
      dec.op_class = OPC_ILLEGAL;
      dec.invalid  = 1'b1;
    end else begin
      case (opcode)
        OP_LUI: begin
          dec.op_class = OPC_LUI;
          dec.rd       = rd_f;
          dec.imm      = imm_u;
          rd_class     = 1'b1;
        end
        OP_AUIPC: begin
          dec.op_class = OPC_AUIPC;
          dec.rd       = rd_f;
          dec.imm      = imm_u;
          rd_class     = 1'b1;
        end
        OP_JAL: begin
          dec.op_class = OPC_JAL;
          dec.rd       = rd_f;
          dec.imm      = imm_j;
          rd_class     = 1'b1;
        end
        OP_JALR, OP_LOAD, OP_IMM_REG_ALU: begin
          dec.op_class = (opcode == OP_JALR) ? OPC_JALR :
                         (opcode == OP_LOAD) ? OPC_LOAD : OPC_ALU_IMM;
          dec.rd       = rd_f;
          dec.rs1      = rs1_f;
          dec.rs1_used = 1'b1;
          dec.imm      = imm_i;
          rd_class     = 1'b1;
        end
        OP_STORE, OP_BRANCH: begin
          dec.op_class = (opcode == OP_STORE) ? OPC_STORE : OPC_BRANCH;
          dec.rs1      = rs1_f;
          dec.rs2      = rs2_f;
          dec.rs1_used = 1'b1;
          dec.rs2_used = 1'b1;
          dec.imm      = (opcode == OP_STORE) ? imm_s : imm_b;
        end
        OP_REG_REG_ALU: begin
          dec.op_class = OPC_ALU_REG;
          dec.rd       = rd_f;
          dec.rs1      = rs1_f;
          dec.rs2      = rs2_f;
          dec.rs1_used = 1'b1;
          dec.rs2_used = 1'b1;
          rd_class     = 1'b1;
        end
        OP_FENCE:  dec.op_class = OPC_FENCE;
        OP_SYSTEM: dec.op_class = OPC_SYSTEM;
        default: begin
          dec.op_class = OPC_ILLEGAL;
          dec.invalid  = 1'b1;
        end
      endcase
    end
    dec.rd_we = rd_class && (rd_f != 5'd0);
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode pipeline stage with valid/ready on both sides, optional 2-entry skid,
// flush from branch resolution and a saturating illegal-instruction counter.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int CNT_W   = 16,
  parameter int SKID_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [3:0]       out_op_class,
  output logic             out_rs1_used,
  output logic             out_rs2_used,
  output logic             out_rd_we,
  output logic             out_invalid,
  output logic [CNT_W-1:0] invalid_count
);

  decoded_t         in_dec;
  decoded_t         main_q;
  decoded_t         skid_q;
  logic             main_valid;
  logic             skid_valid;
  logic             in_xfer;
  logic             out_xfer;
  logic [CNT_W-1:0] count_q;

  decode_fields #(.XLEN(XLEN)) u_fields (
    .instr (in_instr),
    .pc    (in_pc),
    .dec   (in_dec)
  );

  // Without the skid entry the stage can only accept when its single register frees up.
  if (SKID_EN != 0) begin : g_skid_ready
    assign in_ready = !skid_valid;
  end else begin : g_reg_ready
    assign in_ready = !main_valid || out_ready;
  end

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = main_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
      count_q    <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (!main_valid || out_xfer) begin
        // The skid entry is older than any incoming instruction, so it refills main first.
        if (skid_valid) begin
          main_q     <= skid_q;
          main_valid <= 1'b1;
          skid_valid <= 1'b0;
        end else if (in_xfer) begin
          main_q     <= in_dec;
          main_valid <= 1'b1;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (in_xfer) begin
        skid_q     <= in_dec;
        skid_valid <= 1'b1;
      end
      if (in_xfer && in_dec.invalid && (count_q != {CNT_W{1'b1}})) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign out_valid     = main_valid;
  assign out_pc        = main_q.pc[XLEN-1:0];
  assign out_rs1       = main_q.rs1;
  assign out_rs2       = main_q.rs2;
  assign out_rd        = main_q.rd;
  assign out_imm       = main_q.imm[XLEN-1:0];
  assign out_funct3    = main_q.funct3;
  assign out_funct7    = main_q.funct7;
  assign out_op_class  = main_q.op_class;
  assign out_rs1_used  = main_q.rs1_used;
  assign out_rs2_used  = main_q.rs2_used;
  assign out_rd_we     = main_q.rd_we;
  assign out_invalid   = main_q.invalid;
  assign invalid_count = count_q;

  if (XLEN < XLEN_MAX) begin : g_narrow
    logic unused_hi;
    assign unused_hi = ^{main_q.pc[XLEN_MAX-1:XLEN], main_q.imm[XLEN_MAX-1:XLEN]};
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; a second CNT_W=2 instance checks saturation.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [3:0]  out_op_class;
  logic        out_rs1_used;
  logic        out_rs2_used;
  logic        out_rd_we;
  logic        out_invalid;
  logic [15:0] invalid_count;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_out_pc;
  logic [4:0]  s_out_rs1;
  logic [4:0]  s_out_rs2;
  logic [4:0]  s_out_rd;
  logic [31:0] s_out_imm;
  logic [2:0]  s_out_funct3;
  logic [6:0]  s_out_funct7;
  logic [3:0]  s_out_op_class;
  logic        s_out_rs1_used;
  logic        s_out_rs2_used;
  logic        s_out_rd_we;
  logic        s_out_invalid;
  logic [1:0]  s_invalid_count;

  int vectors;
  int miscompares;

  decode_stage #(.XLEN(32), .CNT_W(16), .SKID_EN(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_rs1       (out_rs1),
    .out_rs2       (out_rs2),
    .out_rd        (out_rd),
    .out_imm       (out_imm),
    .out_funct3    (out_funct3),
    .out_funct7    (out_funct7),
    .out_op_class  (out_op_class),
    .out_rs1_used  (out_rs1_used),
    .out_rs2_used  (out_rs2_used),
    .out_rd_we     (out_rd_we),
    .out_invalid   (out_invalid),
    .invalid_count (invalid_count)
  );

  decode_stage #(.XLEN(32), .CNT_W(2), .SKID_EN(1)) dut_sat (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (s_in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .out_valid     (s_out_valid),
    .out_ready     (out_ready),
    .out_pc        (s_out_pc),
    .out_rs1       (s_out_rs1),
    .out_rs2       (s_out_rs2),
    .out_rd        (s_out_rd),
    .out_imm       (s_out_imm),
    .out_funct3    (s_out_funct3),
    .out_funct7    (s_out_funct7),
    .out_op_class  (s_out_op_class),
    .out_rs1_used  (s_out_rs1_used),
    .out_rs2_used  (s_out_rs2_used),
    .out_rd_we     (s_out_rd_we),
    .out_invalid   (s_out_invalid),
    .invalid_count (s_invalid_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic v, input logic [31:0] instr,
                                input logic [31:0] pc, input logic rdy);
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    flush       = 1'b0;
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    check_output("rst_out_valid", 64'(out_valid), 64'h0);
    check_output("rst_op_class", 64'(out_op_class), 64'h0);
    check_output("rst_imm", 64'(out_imm), 64'h0);
    check_output("rst_count", 64'(invalid_count), 64'h0);
    rst = 1'b0;
    check_output("rst_in_ready", 64'(in_ready), 64'h1);

    // addi x1,x0,5
    apply_stimulus(1'b1, 32'h00500093, 32'h100, 1'b1);
    tick();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
    check_output("addi_valid", 64'(out_valid), 64'h1);
    check_output("addi_pc", 64'(out_pc), 64'h100);
    check_output("addi_rd", 64'(out_rd), 64'h1);
    check_output("addi_rs1", 64'(out_rs1), 64'h0);
    check_output("addi_imm", 64'(out_imm), 64'h5);
    check_output("addi_class", 64'(out_op_class), 64'd8);
    check_output("addi_rd_we", 64'(out_rd_we), 64'h1);
    check_output("addi_rs1_used", 64'(out_rs1_used), 64'h1);
    check_output("addi_rs2_used", 64'(out_rs2_used), 64'h0);
    tick();
    check_output("drain_valid", 64'(out_valid), 64'h0);

    // beq x1,x2,-4
    apply_stimulus(1'b1, 32'hFE208EE3, 32'h200, 1'b1);
    tick();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
    check_output("beq_imm", 64'(out_imm), 64'hFFFFFFFC);
    check_output("beq_rs1", 64'(out_rs1), 64'h1);
    check_output("beq_rs2", 64'(out_rs2), 64'h2);
    check_output("beq_rd", 64'(out_rd), 64'h0);
    check_output("beq_rd_we", 64'(out_rd_we), 64'h0);
    check_output("beq_class", 64'(out_op_class), 64'd5);

    // sw x2,8(x1)
    apply_stimulus(1'b1, 32'h0020A423, 32'h204, 1'b1);
    tick();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
    check_output("sw_imm", 64'(out_imm), 64'h8);
    check_output("sw_class", 64'(out_op_class), 64'd7);
    check_output("sw_funct3", 64'(out_funct3), 64'h2);
    check_output("sw_rs2_used", 64'(out_rs2_used), 64'h1);
    tick();

    // Back-pressure: two accepts fill main and skid, third is held off
    apply_stimulus(1'b1, 32'h123452B7, 32'h0, 1'b0);
    tick();
    check_output("bp_ready_1", 64'(in_ready), 64'h1);
    apply_stimulus(1'b1, 32'h123452B7, 32'h4, 1'b0);
    tick();
    check_output("bp_ready_2", 64'(in_ready), 64'h0);
    apply_stimulus(1'b1, 32'h123452B7, 32'h8, 1'b0);
    tick();
    check_output("bp_hold_pc", 64'(out_pc), 64'h0);
    check_output("bp_hold_ready", 64'(in_ready), 64'h0);
    apply_stimulus(1'b1, 32'h123452B7, 32'h8, 1'b1);
    tick();
    check_output("bp_pc_4", 64'(out_pc), 64'h4);
    check_output("bp_ready_back", 64'(in_ready), 64'h1);
    tick();
    check_output("bp_pc_8", 64'(out_pc), 64'h8);
    apply_stimulus(1'b1, 32'h123452B7, 32'hC, 1'b1);
    tick();
    check_output("bp_pc_c", 64'(out_pc), 64'hC);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    check_output("bp_empty", 64'(out_valid), 64'h0);

    // Flush with both entries full
    apply_stimulus(1'b1, 32'h00500093, 32'h20, 1'b0);
    tick();
    apply_stimulus(1'b1, 32'h00500093, 32'h24, 1'b0);
    tick();
    apply_stimulus(1'b1, 32'h00500093, 32'h28, 1'b0);
    flush = 1'b1;
    tick();
    check_output("flush_valid", 64'(out_valid), 64'h0);
    check_output("flush_ready", 64'(in_ready), 64'h1);
    // Flush while ready: the illegal instruction presented must be dropped and not counted
    apply_stimulus(1'b1, 32'h00000000, 32'h30, 1'b1);
    tick();
    flush = 1'b0;
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
    check_output("flush_drop_valid", 64'(out_valid), 64'h0);
    check_output("flush_count", 64'(invalid_count), 64'h0);
    tick();
    check_output("flush_still_empty", 64'(out_valid), 64'h0);

    // Illegal instructions
    apply_stimulus(1'b1, 32'h00000000, 32'h40, 1'b1);
    tick();
    check_output("ill0_invalid", 64'(out_invalid), 64'h1);
    check_output("ill0_class", 64'(out_op_class), 64'd12);
    check_output("ill0_count", 64'(invalid_count), 64'h1);
    apply_stimulus(1'b1, 32'hFFFFFFFF, 32'h44, 1'b1);
    tick();
    check_output("ill1_invalid", 64'(out_invalid), 64'h1);
    check_output("ill1_class", 64'(out_op_class), 64'd12);
    check_output("ill1_rs1", 64'(out_rs1), 64'h0);
    check_output("ill1_imm", 64'(out_imm), 64'h0);
    check_output("ill1_count", 64'(invalid_count), 64'h2);
    apply_stimulus(1'b1, 32'h0000007F, 32'h48, 1'b1);
    tick();
    check_output("ill2_count", 64'(invalid_count), 64'h3);
    check_output("sat_count_3", 64'(s_invalid_count), 64'h3);
    apply_stimulus(1'b1, 32'h00500091, 32'h4C, 1'b1);
    tick();
    check_output("ill3_class", 64'(out_op_class), 64'd12);
    check_output("ill3_rd_we", 64'(out_rd_we), 64'h0);
    apply_stimulus(1'b1, 32'h00000000, 32'h50, 1'b1);
    tick();
    check_output("ill4_count", 64'(invalid_count), 64'h5);
    check_output("sat_count_5", 64'(s_invalid_count), 64'h3);

    // lui x0 and lui x5
    apply_stimulus(1'b1, 32'h12345037, 32'h60, 1'b1);
    tick();
    check_output("lui0_class", 64'(out_op_class), 64'd1);
    check_output("lui0_imm", 64'(out_imm), 64'h12345000);
    check_output("lui0_rd_we", 64'(out_rd_we), 64'h0);
    apply_stimulus(1'b1, 32'h123452B7, 32'h64, 1'b1);
    tick();
    check_output("lui5_rd", 64'(out_rd), 64'h5);
    check_output("lui5_rd_we", 64'(out_rd_we), 64'h1);
    check_output("legal_count", 64'(invalid_count), 64'h5);

    // Reset while two entries are held
    apply_stimulus(1'b1, 32'h123452B7, 32'h70, 1'b0);
    tick();
    apply_stimulus(1'b1, 32'h123452B7, 32'h74, 1'b0);
    tick();
    check_output("pre_rst_ready", 64'(in_ready), 64'h0);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("mrst_valid", 64'(out_valid), 64'h0);
    check_output("mrst_pc", 64'(out_pc), 64'h0);
    check_output("mrst_rd", 64'(out_rd), 64'h0);
    check_output("mrst_imm", 64'(out_imm), 64'h0);
    check_output("mrst_class", 64'(out_op_class), 64'h0);
    check_output("mrst_count", 64'(invalid_count), 64'h0);
    check_output("mrst_ready", 64'(in_ready), 64'h1);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    check_output("mrst_no_ghost", 64'(out_valid), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
